// File: rtl/mm_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_cfg_pkg
// Description : Shared constants and types for the configuration write
//               sequencer: FSM state encoding and write-count width.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_cfg_pkg;

    // State encoding of the write-sequencer FSM
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_IDLE,
        ST_LOAD  = c_LOAD,
        ST_FLUSH = c_FLUSH,
        ST_CLEAR = c_CLEAR
    } state_t;

    // Width of the committed-write counter and its saturation value
    localparam int                    c_WCOUNT_W   = 8;
    localparam logic [c_WCOUNT_W-1:0] c_WCOUNT_MAX = '1;

endpackage : mm_cfg_pkg
`default_nettype wire

// File: rtl/mm_addr_dec.sv
`default_nettype none
// ============================================================================
// Module      : mm_addr_dec
// Description : Combinational one-hot address decoder. Produces one enable
//               bit per implemented register and flags addresses that fall
//               beyond the implemented register count.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_addr_dec
    import mm_cfg_pkg::*;
#(
    parameter int SIZEADDR = 3,
    parameter int NREGS    = 8
) (
    input  logic [SIZEADDR-1:0] addr,
    output logic [NREGS-1:0]    onehot,
    output logic                oor
);

    // Addresses at or above NREGS select nothing; compare in 32 bits so the
    // check is exact whatever the address width is.
    assign oor = (32'(addr) >= 32'(NREGS));

    // One comparator per implemented register; out-of-range addresses match
    // no bit, so the vector is naturally all-zero for them.
    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        assign onehot[i] = (32'(addr) == 32'(i));
    end

endmodule : mm_addr_dec
`default_nettype wire

// File: rtl/mm_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : mm_cfg_loader
// Description : Write sequencer feeding a bank of enable/clear configuration
//               registers. Accepts a burst of (address, data) beats over a
//               valid/ready handshake, drives a shared data bus with one-hot
//               per-register enable pulses, issues bank-wide clears, and
//               reports busy/done/error status and a saturating write count.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_cfg_loader
    import mm_cfg_pkg::*;
#(
    parameter int SIZEDATA = 32,
    parameter int NREGS    = 8,
    parameter int SIZEADDR = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear_req,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SIZEADDR-1:0]   wr_addr,
    input  logic [SIZEDATA-1:0]   wr_data,
    input  logic                  wr_last,
    output logic [NREGS-1:0]      reg_enable,
    output logic                  reg_clear,
    output logic [SIZEDATA-1:0]   reg_datain,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [c_WCOUNT_W-1:0] wcount
);

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    w_wr_ready;
    logic                    w_accept;
    logic                    w_burst_start;
    logic                    w_busy;
    logic                    w_reg_clear;

    logic [NREGS-1:0]        w_dec_onehot;
    logic                    w_dec_oor;

    logic [NREGS-1:0]        r_reg_enable;
    logic [SIZEDATA-1:0]     r_reg_datain;
    logic                    r_done;
    logic                    r_err;
    logic [c_WCOUNT_W-1:0]   r_wcount;

    mm_addr_dec #(
        .SIZEADDR (SIZEADDR),
        .NREGS    (NREGS)
    ) u_addr_dec (
        .addr   (wr_addr),
        .onehot (w_dec_onehot),
        .oor    (w_dec_oor)
    );

    // State register; reset drops straight back to IDLE mid-burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded controls. A clear request always wins:
    // over start in IDLE, and over any pending beat in LOAD (where it also
    // withdraws ready so that beat is never committed).
    always_comb begin
        w_state_next  = r_state;
        w_wr_ready    = 1'b0;
        w_burst_start = 1'b0;
        w_busy        = 1'b1;
        w_reg_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (clear_req) begin
                    w_state_next = ST_CLEAR;
                end else if (start) begin
                    w_state_next  = ST_LOAD;
                    w_burst_start = 1'b1;
                end
            end
            ST_LOAD: begin
                w_wr_ready = !clear_req;
                if (clear_req) begin
                    w_state_next = ST_CLEAR;
                end else if (wr_valid && wr_last) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_next = ST_IDLE;
            end
            ST_CLEAR: begin
                w_reg_clear  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = wr_valid && w_wr_ready;

    // Commit accepted beats one cycle later: data bus, enable pulse, error
    // flag and saturating count. Enables default to zero every cycle so a
    // pulse only ever follows an accepted beat. Done fires on leaving FLUSH,
    // i.e. the cycle after the final enable pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_enable <= '0;
            r_reg_datain <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_wcount     <= '0;
        end else begin
            r_reg_enable <= '0;
            r_done       <= (r_state == ST_FLUSH);
            if (w_burst_start) begin
                r_wcount <= '0;
                r_err    <= 1'b0;
            end
            if (w_accept) begin
                r_reg_datain <= wr_data;
                if (w_dec_oor) begin
                    r_err <= 1'b1;
                end else begin
                    r_reg_enable <= w_dec_onehot;
                end
                if (r_wcount != c_WCOUNT_MAX) begin
                    r_wcount <= r_wcount + 1'b1;
                end
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign busy       = w_busy;
    assign reg_clear  = w_reg_clear;
    assign reg_enable = r_reg_enable;
    assign reg_datain = r_reg_datain;
    assign done       = r_done;
    assign err        = r_err;
    assign wcount     = r_wcount;

endmodule : mm_cfg_loader
`default_nettype wire

// File: doc/mm_cfg_loader.md
Name: mm_cfg_loader

Overview:
- Write-sequencer that sits directly upstream of a bank of enable/clear configuration registers in the memory-mapped coprocessor.
- Accepts a burst of (address, data) writes over a valid/ready handshake.
- Drives a shared data bus, one-hot per-register enable pulses, and a bank-wide clear pulse.
- Reports busy/done/error status and a saturating write count to the host-side control logic.

Parameters:
- SIZEDATA, 32, width of configuration data bus and of each downstream register
- NREGS, 8, number of downstream registers (enable vector width)
- SIZEADDR, 3, width of write address; NREGS <= 2**SIZEADDR

Ports:
- clk  input  1  system clock
- reset  input  1  system reset, asynchronous, active-high
- start  input  1  pulse: begin accepting a write burst
- clear_req  input  1  pulse: clear the whole register bank
- wr_valid  input  1  write beat valid
- wr_ready  output  1  write beat accepted when wr_valid && wr_ready
- wr_addr  input  SIZEADDR  target register index
- wr_data  input  SIZEDATA  write data
- wr_last  input  1  marks final beat of the burst
- reg_enable  output  NREGS  one-hot enable to register i, one-cycle pulse
- reg_clear  output  1  clear to all registers, one-cycle pulse
- reg_datain  output  SIZEDATA  shared data to all registers
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after last beat committed
- err  output  1  sticky: an out-of-range address was written
- wcount  output  8  committed writes in the current burst, saturates at 255

Behaviour:
- Reset is asynchronous and active-high, using clk and reset only.
- Reset values: all outputs 0 (reg_enable=0, reg_clear=0, reg_datain=0, done=0, err=0, wcount=0, busy=0, wr_ready=0). State goes to IDLE.
- FSM states: IDLE, LOAD, FLUSH, CLEAR.
- IDLE:
  - clear_req -> CLEAR. clear_req has priority over start in the same cycle.
  - else start -> LOAD; wcount<=0 and err<=0 on entry.
- LOAD:
  - wr_ready = 1 when state==LOAD && !clear_req (combinational from state and clear_req).
  - Accepted beat, registered with 1-cycle latency:
    - reg_datain<=wr_data.
    - reg_enable<=onehot(wr_addr) if wr_addr<NREGS; otherwise reg_enable<=0 and err<=1.
    - wcount<=wcount+1, saturating at 255; out-of-range beats also count.
  - Accepted beat with wr_last -> FLUSH.
  - clear_req in LOAD aborts the burst: no beat accepted that cycle -> CLEAR.
- FLUSH: one cycle; done<=1 (visible the cycle after the final reg_enable pulse); -> IDLE.
- CLEAR: reg_clear=1 for exactly one cycle; reg_enable=0; -> IDLE. No done pulse.
- reg_enable and reg_clear are never asserted in the same cycle.
- reg_enable is 0 on any cycle with no accepted beat.
- reg_datain holds its last value between beats.
- start outside IDLE: ignored. clear_req outside IDLE/LOAD: ignored.
- Back-to-back beats: one beat per cycle sustained; consecutive enable pulses may target the same or different registers.
- Reset mid-burst: immediate return to IDLE. Downstream registers receive no partial enable after reset deasserts.

Decomposition:
- Shared package (mm_cfg_pkg): state encoding localparams (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2, CLEAR=2'd3) and the wcount width constant (8).
- One sub-module: mm_addr_dec, a combinational one-hot decoder (SIZEADDR -> NREGS) with an out-of-range flag output.

Test Plan:
- Basic burst: start, then beats (addr 0, 0xA5A5A5A5), (addr 3, 0x12345678), (addr 7, 0xFFFFFFFF, last).
  - reg_enable = 0x01, 0x08, 0x80 on consecutive cycles with matching reg_datain.
  - done one cycle later; wcount=3; err=0; 8-register bank model holds those values.
- Backpressure: wr_valid toggled 1/0/1 with 2 beats.
  - Exactly 2 enable pulses, none on idle cycles; wcount=2.
- Out of range: NREGS=5, beat addr 6 data 0x55.
  - reg_enable=0 that cycle; err=1 and stays 1 after done.
  - A subsequent start clears err to 0.
- Abort: start, 1 beat to addr 2, then clear_req together with a valid beat to addr 4.
  - wr_ready=0 that cycle; reg_clear pulses once; no done; no enable for addr 4.
- Saturation/priority: 300-beat burst gives wcount=255. start and clear_req in the same IDLE cycle -> CLEAR only, busy for 1 cycle.
- Reset mid-burst: reset asserted 2 cycles into LOAD.
  - All outputs 0 asynchronously; state IDLE; no reg_enable after release until a new start.
